// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
// The arctangent table is held at Q2.30 and narrowed to the operand width by the ROM.
package cordic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int ATAN_ENTRIES = 30;

   // Reciprocal CORDIC gain 1/An, Q2.30; callers scale to their own width.
   localparam logic [31:0] K_Q30 = 32'd652032874;

   function automatic logic [31:0] atan_q30(input logic [31:0] idx);
      logic [31:0] value;
      case (idx)
         32'd0:   value = 32'd843314857;
         32'd1:   value = 32'd497837829;
         32'd2:   value = 32'd263043837;
         32'd3:   value = 32'd133525159;
         32'd4:   value = 32'd67021687;
         32'd5:   value = 32'd33543516;
         32'd6:   value = 32'd16775851;
         32'd7:   value = 32'd8388437;
         32'd8:   value = 32'd4194283;
         32'd9:   value = 32'd2097149;
         32'd10:  value = 32'd1048576;
         32'd11:  value = 32'd524288;
         32'd12:  value = 32'd262144;
         32'd13:  value = 32'd131072;
         32'd14:  value = 32'd65536;
         32'd15:  value = 32'd32768;
         32'd16:  value = 32'd16384;
         32'd17:  value = 32'd8192;
         32'd18:  value = 32'd4096;
         32'd19:  value = 32'd2048;
         32'd20:  value = 32'd1024;
         32'd21:  value = 32'd512;
         32'd22:  value = 32'd256;
         32'd23:  value = 32'd128;
         32'd24:  value = 32'd64;
         32'd25:  value = 32'd32;
         32'd26:  value = 32'd16;
         32'd27:  value = 32'd8;
         32'd28:  value = 32'd4;
         32'd29:  value = 32'd2;
         default: value = 32'd0;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: atan(2^-idx) in Q2.(W-2), truncated from the Q2.30 table.
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int W  = 32,
   parameter int CW = 5
) (
   input  logic [CW-1:0] idx,
   output logic [W-1:0]  angle
);

   localparam int SHIFT = 30 - (W - 2);

   logic [31:0] raw;

   always_comb begin
      raw   = atan_q30(32'(idx));
      angle = W'($signed(raw) >>> SHIFT);
   end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC: one micro-rotation per clock through a single add/shift datapath per axis.
// Rotation mode drives z toward 0, vectoring mode drives y toward 0; gain is left uncompensated.
module cordic_iter_engine
   import cordic_pkg::*;
#(
   parameter int W    = 32,
   parameter int ITER = 24,
   parameter int CW   = $clog2(ITER + 1)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] x_in,
   input  logic [W-1:0] y_in,
   input  logic [W-1:0] z_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] x_out,
   output logic [W-1:0] y_out,
   output logic [W-1:0] z_out
);

   if (ITER < 1 || ITER > W - 2 || W > 32) begin : g_param_check
      $error("cordic_iter_engine: ITER must lie in 1..W-2 and W must not exceed 32");
   end

   state_t         state;
   logic           mode_r;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   x_r;
   logic [W-1:0]   y_r;
   logic [W-1:0]   z_r;
   logic [W-1:0]   x_sh;
   logic [W-1:0]   y_sh;
   logic [W-1:0]   atan_i;
   logic [W-1:0]   x_nx;
   logic [W-1:0]   y_nx;
   logic [W-1:0]   z_nx;
   logic           sigma_pos;
   logic           sigma_neg;

   cordic_atan_rom #(
      .W  (W),
      .CW (CW)
   ) u_atan_rom (
      .idx   (cnt),
      .angle (atan_i)
   );

   // Subtraction is an add of the ones-complement with carry-in 1, so each axis needs one adder.
   always_comb begin
      x_sh      = $signed(x_r) >>> cnt;
      y_sh      = $signed(y_r) >>> cnt;
      sigma_pos = mode_r ? y_r[W-1] : ~z_r[W-1];
      sigma_neg = ~sigma_pos;
      x_nx      = x_r + (sigma_pos ? ~y_sh : y_sh) + W'(sigma_pos);
      y_nx      = y_r + (sigma_pos ? x_sh : ~x_sh) + W'(sigma_neg);
      z_nx      = z_r + (sigma_pos ? ~atan_i : atan_i) + W'(sigma_pos);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         mode_r <= 1'b0;
         x_r    <= '0;
         y_r    <= '0;
         z_r    <= '0;
         x_out  <= '0;
         y_out  <= '0;
         z_out  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  x_r    <= x_in;
                  y_r    <= y_in;
                  z_r    <= z_in;
                  mode_r <= mode;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               x_r <= x_nx;
               y_r <= y_nx;
               z_r <= z_nx;
               if (cnt == CW'(ITER - 1)) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  x_out <= x_nx;
                  y_out <= y_nx;
                  z_out <= z_nx;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine at W=16, ITER=14 (1.0 = 16384) with +/-4 LSB tolerance.
module tb_cordic_iter_engine;

   localparam int W    = 16;
   localparam int ITER = 14;
   localparam int TOL  = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic [W-1:0] x_in = '0;
   logic [W-1:0] y_in = '0;
   logic [W-1:0] z_in = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] x_out;
   logic [W-1:0] y_out;
   logic [W-1:0] z_out;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   cordic_iter_engine #(
      .W    (W),
      .ITER (ITER)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .mode    (mode),
      .x_in    (x_in),
      .y_in    (y_in),
      .z_in    (z_in),
      .busy    (busy),
      .done    (done),
      .x_out   (x_out),
      .y_out   (y_out),
      .z_out   (z_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input int obs, input int exp, input int tol);
      int diff;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      checks++;
      assert ((diff <= tol) === 1'b1) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic apply_stimulus(input logic m, input int x, input int y, input int z);
      mode  = m;
      x_in  = W'(x);
      y_in  = W'(y);
      z_in  = W'(z);
      start = 1'b1;
   endtask

   task automatic check_output(input string tag, input int ex, input int ey, input int ez);
      check_val({tag, ".x"}, int'($signed(x_out)), ex, TOL);
      check_val({tag, ".y"}, int'($signed(y_out)), ey, TOL);
      check_val({tag, ".z"}, int'($signed(z_out)), ez, TOL);
   endtask

   // Counts edges until done is seen, bounded so a stuck DUT still reaches the summary.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int n2;
      bit seen;

      #1 reset_n = 1'b0;
      #2;
      check_val("reset.busy", int'(busy), 0, 0);
      check_val("reset.done", int'(done), 0, 0);
      check_val("reset.x", int'($signed(x_out)), 0, 0);
      check_val("reset.y", int'($signed(y_out)), 0, 0);
      check_val("reset.z", int'($signed(z_out)), 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      $display("[TB] rotation pi/4");
      apply_stimulus(1'b0, 9949, 0, 12868);
      tick();
      start = 1'b0;
      check_val("t1.busy_after_accept", int'(busy), 1, 0);
      check_val("t1.done_after_accept", int'(done), 0, 0);
      wait_done(n);
      check_val("t1.latency", n, ITER, 0);
      check_val("t1.busy_at_done", int'(busy), 0, 0);
      check_output("t1", 11585, 11585, 0);
      tick();
      check_val("t1.done_one_cycle", int'(done), 0, 0);
      check_output("t1.hold", 11585, 11585, 0);

      $display("[TB] rotation 0 and -pi/2");
      apply_stimulus(1'b0, 9949, 0, 0);
      tick();
      start = 1'b0;
      wait_done(n);
      check_val("t2a.latency", n, ITER, 0);
      check_output("t2a", 16384, 0, 0);
      apply_stimulus(1'b0, 9949, 0, -25736);
      tick();
      start = 1'b0;
      wait_done(n);
      check_val("t2b.latency", n, ITER, 0);
      check_output("t2b", 0, -16384, 0);

      $display("[TB] vectoring 45 deg");
      apply_stimulus(1'b1, 8192, 8192, 0);
      tick();
      start = 1'b0;
      wait_done(n);
      check_val("t3.latency", n, ITER, 0);
      check_output("t3", 19078, 0, 12868);

      $display("[TB] start pulses during RUN");
      apply_stimulus(1'b0, 9949, 0, 12868);
      tick();
      start = 1'b0;
      tick();
      tick();
      apply_stimulus(1'b1, 8192, 8192, 0);
      tick();
      start = 1'b0;
      check_val("t4.busy_mid", int'(busy), 1, 0);
      repeat (5) tick();
      apply_stimulus(1'b1, 8192, 8192, 0);
      tick();
      start = 1'b0;
      wait_done(n);
      check_val("t4.latency_rest", n, ITER - 9, 0);
      check_output("t4", 11585, 11585, 0);
      tick();
      tick();
      check_val("t4.no_queued_busy", int'(busy), 0, 0);
      check_val("t4.no_queued_done", int'(done), 0, 0);

      $display("[TB] reset during RUN");
      apply_stimulus(1'b1, 8192, 8192, 0);
      tick();
      start = 1'b0;
      repeat (6) tick();
      #2 reset_n = 1'b0;
      #1;
      check_val("t5.busy", int'(busy), 0, 0);
      check_val("t5.done", int'(done), 0, 0);
      check_val("t5.x", int'($signed(x_out)), 0, 0);
      check_val("t5.y", int'($signed(y_out)), 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (done === 1'b1) seen = 1'b1;
      end
      check_val("t5.no_done", int'(seen), 0, 0);
      apply_stimulus(1'b1, 8192, 8192, 0);
      tick();
      start = 1'b0;
      wait_done(n);
      check_val("t5.latency", n, ITER, 0);
      check_output("t5.rerun", 19078, 0, 12868);

      $display("[TB] back-to-back via held start");
      apply_stimulus(1'b0, 9949, 0, 0);
      tick();
      apply_stimulus(1'b1, 8192, 8192, 0);
      wait_done(n);
      check_val("t6.latency1", n, ITER, 0);
      check_output("t6.op1", 16384, 0, 0);
      tick();
      start = 1'b0;
      check_val("t6.busy_restart", int'(busy), 1, 0);
      check_val("t6.done_low", int'(done), 0, 0);
      wait_done(n2);
      check_val("t6.done_spacing", n2 + 1, ITER + 1, 0);
      check_output("t6.op2", 19078, 0, 12868);
      tick();
      check_val("t6.idle_busy", int'(busy), 0, 0);
      check_val("t6.idle_done", int'(done), 0, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
